// File: rtl/byang_inv_check_if.sv
// Handshake and result bundle between an operand source and the inverse checker.
// The master drives the operand pair and the result back-pressure; the slave is the checker.
interface byang_inv_check_if #(
    parameter int unsigned PRIME_BITS = 256,
    parameter int unsigned CTR_WIDTH  = 16
);
    logic                  valid_in;
    logic                  ready_in;
    logic [PRIME_BITS-1:0] a_in;
    logic [PRIME_BITS-1:0] r_in;
    logic                  valid_out;
    logic                  ready_out;
    logic [PRIME_BITS-1:0] product;
    logic                  pass;
    logic [CTR_WIDTH-1:0]  cycle_count;
    logic [CTR_WIDTH-1:0]  perf_pass_count;
    logic [CTR_WIDTH-1:0]  perf_fail_count;

    modport master (
        output valid_in, a_in, r_in, ready_out,
        input  ready_in, valid_out, product, pass, cycle_count,
               perf_pass_count, perf_fail_count
    );

    modport slave (
        input  valid_in, a_in, r_in, ready_out,
        output ready_in, valid_out, product, pass, cycle_count,
               perf_pass_count, perf_fail_count
    );
endinterface

// File: rtl/byang_inv_check.sv
// Verifies a claimed modular inverse by computing (a*r) mod p for the secp256k1 prime with a
// bit-serial MSB-first interleaved multiplier; one-entry input buffer and registered output.
module byang_inv_check #(
    parameter int unsigned PRIME_BITS = 256,
    parameter int unsigned CTR_WIDTH  = 16
) (
    input logic              clk,
    input logic              rst_n,
    byang_inv_check_if.slave chk_io
);
    localparam int unsigned IdxW = $clog2(PRIME_BITS);
    localparam logic [PRIME_BITS-1:0] SECP256K1_P = PRIME_BITS'(
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F);
    localparam logic [PRIME_BITS:0]   PExt   = {1'b0, SECP256K1_P};
    localparam logic [IdxW-1:0]       IdxTop = IdxW'(PRIME_BITS - 1);
    localparam logic [CTR_WIDTH-1:0]  CtrMax = '1;
    localparam logic [PRIME_BITS:0]   AccOne = (PRIME_BITS + 1)'(1);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCompute = 2'd1,
        StDone    = 2'd2
    } state_e;

    state_e                state_q;
    logic                  in_valid_q;
    logic [PRIME_BITS-1:0] a_buf_q, r_buf_q;
    logic [PRIME_BITS:0]   acc_q;
    logic [PRIME_BITS-1:0] a_q, b_q;
    logic [IdxW-1:0]       idx_q;
    logic [CTR_WIDTH-1:0]  cyc_q;
    logic                  out_valid_q;
    logic [PRIME_BITS-1:0] product_q;
    logic                  pass_q;
    logic [CTR_WIDTH-1:0]  cycle_count_q;
    logic [CTR_WIDTH-1:0]  perf_pass_q, perf_fail_q;

    logic                  capture, out_free, load;
    logic [PRIME_BITS:0]   t_dbl, t_add;

    // Inputs are below 2^PRIME_BITS < 2p, so one conditional subtraction fully reduces.
    function automatic logic [PRIME_BITS-1:0] reduce(input logic [PRIME_BITS-1:0] x);
        return (x >= SECP256K1_P) ? x - SECP256K1_P : x;
    endfunction

    assign capture  = chk_io.valid_in && !in_valid_q;
    assign out_free = !out_valid_q || chk_io.ready_out;
    assign load     = in_valid_q && ((state_q == StIdle) || ((state_q == StDone) && out_free));

    always_comb begin
        t_dbl = acc_q << 1;
        if (t_dbl >= PExt) t_dbl = t_dbl - PExt;
        t_add = t_dbl + (b_q[idx_q] ? {1'b0, a_q} : '0);
        if (t_add >= PExt) t_add = t_add - PExt;
    end

    // Datapath registers are always written on load before use, so they carry no reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            a_buf_q <= chk_io.a_in;
            r_buf_q <= chk_io.r_in;
        end
        if (load) begin
            acc_q <= '0;
            a_q   <= reduce(a_buf_q);
            b_q   <= reduce(r_buf_q);
            idx_q <= IdxTop;
            cyc_q <= '0;
        end else if (state_q == StCompute) begin
            acc_q <= t_add;
            idx_q <= idx_q - IdxW'(1);
            cyc_q <= cyc_q + CTR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            in_valid_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            product_q     <= '0;
            pass_q        <= 1'b0;
            cycle_count_q <= '0;
            perf_pass_q   <= '0;
            perf_fail_q   <= '0;
        end else begin
            if (load) begin
                in_valid_q <= 1'b0;
            end else if (capture) begin
                in_valid_q <= 1'b1;
            end
            if (out_valid_q && chk_io.ready_out) out_valid_q <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (in_valid_q) state_q <= StCompute;
                end
                StCompute: begin
                    if (idx_q == '0) state_q <= StDone;
                end
                StDone: begin
                    if (out_free) begin
                        out_valid_q   <= 1'b1;
                        product_q     <= acc_q[PRIME_BITS-1:0];
                        pass_q        <= (acc_q == AccOne);
                        cycle_count_q <= cyc_q;
                        if (acc_q == AccOne) begin
                            if (perf_pass_q != CtrMax) perf_pass_q <= perf_pass_q + CTR_WIDTH'(1);
                        end else begin
                            if (perf_fail_q != CtrMax) perf_fail_q <= perf_fail_q + CTR_WIDTH'(1);
                        end
                        state_q <= in_valid_q ? StCompute : StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign chk_io.ready_in        = !in_valid_q;
    assign chk_io.valid_out       = out_valid_q;
    assign chk_io.product         = product_q;
    assign chk_io.pass            = pass_q;
    assign chk_io.cycle_count     = cycle_count_q;
    assign chk_io.perf_pass_count = perf_pass_q;
    assign chk_io.perf_fail_count = perf_fail_q;
endmodule

// File: tb/tb_byang_inv_check.sv
// Scoreboard bench for byang_inv_check: expected (a*r) mod p comes from wide integer arithmetic.
module tb_byang_inv_check;
    localparam int unsigned PB = 256;
    localparam int unsigned CW = 16;
    localparam logic [511:0] P512 = (512'd1 << 256) - (512'd1 << 32) - 512'd977;

    typedef struct packed {
        logic [255:0] prod;
        logic         pass;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   rdy_mode = 1;  // 0: hold low, 1: hold high, 2: random
    int   exp_pass_n = 0;
    int   exp_fail_n = 0;
    exp_t sb[$];

    logic         held = 1'b0;
    logic [511:0] snap = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    byang_inv_check_if #(.PRIME_BITS(PB), .CTR_WIDTH(CW)) bus ();

    byang_inv_check #(.PRIME_BITS(PB), .CTR_WIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .chk_io(bus)
    );

    task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [255:0] a, input logic [255:0] r);
        logic [511:0] x;
        exp_t         e;
        x = ((512'(a) % P512) * (512'(r) % P512)) % P512;
        e.prod = x[255:0];
        e.pass = (x == 512'd1);
        return e;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v = '0;
        for (int k = 0; k < 8; k++) v = {v[223:0], 32'($urandom)};
        return v;
    endfunction

    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0) bus.ready_out = 1'b0;
        else if (rdy_mode == 1) bus.ready_out = 1'b1;
        else bus.ready_out = 1'($urandom_range(0, 1));
    end

    // Monitor: output stability under back-pressure and in-order scoreboard checks.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            held = 1'b0;
        end else if (bus.valid_out) begin
            if (held) check("hold_stable", {bus.product, bus.pass, bus.cycle_count}, snap);
            snap = 512'({bus.product, bus.pass, bus.cycle_count});
            held = !bus.ready_out;
            if (bus.ready_out) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", 512'(bus.valid_out), 512'd0);
                end else begin
                    e = sb.pop_front();
                    if (e.pass) begin
                        if (exp_pass_n < 65535) exp_pass_n++;
                    end else begin
                        if (exp_fail_n < 65535) exp_fail_n++;
                    end
                    check("product", 512'(bus.product), 512'(e.prod));
                    check("pass", 512'(bus.pass), 512'(e.pass));
                    check("cycle_count", 512'(bus.cycle_count), 512'(PB));
                    check("perf_pass", 512'(bus.perf_pass_count), 512'(exp_pass_n));
                    check("perf_fail", 512'(bus.perf_fail_count), 512'(exp_fail_n));
                end
            end
        end else begin
            held = 1'b0;
        end
    end

    task automatic send(input logic [255:0] a, input logic [255:0] r, output int ce);
        int n = 0;
        @(posedge clk);
        #1;
        bus.valid_in = 1'b1;
        bus.a_in     = a;
        bus.r_in     = r;
        @(negedge clk);
        while (!bus.ready_in && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) check("send_timeout", 512'(n), 512'd0);
        ce = cyc + 1;
        sb.push_back(model(a, r));
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((sb.size() != 0 || bus.valid_out) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) check(name, 512'(sb.size()), 512'd0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ready_in"}, 512'(bus.ready_in), 512'd1);
        check({tag, "_valid_out"}, 512'(bus.valid_out), 512'd0);
        check({tag, "_product"}, 512'(bus.product), 512'd0);
        check({tag, "_pass"}, 512'(bus.pass), 512'd0);
        check({tag, "_cycle_count"}, 512'(bus.cycle_count), 512'd0);
        check({tag, "_perf_pass"}, 512'(bus.perf_pass_count), 512'd0);
        check({tag, "_perf_fail"}, 512'(bus.perf_fail_count), 512'd0);
    endtask

    initial begin
        int           ce;
        int           n;
        int           t0;
        logic         seen;
        logic [255:0] a;
        logic [255:0] r;
        exp_t         first;

        bus.valid_in = 1'b0;
        bus.a_in     = '0;
        bus.r_in     = '0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // a=1, r=1 from idle, with capture-to-valid latency
        send(256'd1, 256'd1, ce);
        n = 0;
        while (!bus.valid_out && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("latency", 512'(cyc + 1 - ce), 512'(PB + 3));
        wait_drain("drain_one");

        // (p+1)/2 is the inverse of 2
        r = 256'((P512 + 512'd1) >> 1);
        send(256'd2, r, ce);
        send(256'(P512 + 512'd1), 256'd5, ce);
        send(256'd0, 256'd7, ce);
        send(rand256(), 256'd0, ce);
        wait_drain("drain_directed");

        // Random operands, some unreduced, under random back-pressure
        rdy_mode = 2;
        for (int i = 0; i < 10; i++) begin
            a = rand256();
            r = rand256();
            if (i % 4 == 1) a = 256'(P512 + 512'($urandom_range(0, 1000)));
            if (i % 4 == 3) r = 256'(P512 + 512'($urandom_range(0, 1000)));
            send(a, r, ce);
        end
        rdy_mode = 1;
        wait_drain("drain_random");

        // Three pairs with the output blocked for 600 cycles
        rdy_mode = 0;
        @(posedge clk);
        t0 = cyc;
        first = model(256'd1, 256'd1);
        send(256'd1, 256'd1, ce);
        send(256'd3, 256'd4, ce);
        send(rand256(), rand256(), ce);
        while (cyc < t0 + 600) @(negedge clk);
        check("blocked_valid_out", 512'(bus.valid_out), 512'd1);
        check("blocked_product", 512'(bus.product), 512'(first.prod));
        check("blocked_ready_in", 512'(bus.ready_in), 512'd0);
        check("blocked_queue", 512'(sb.size()), 512'd3);
        rdy_mode = 1;
        wait_drain("drain_blocked");

        // Reset in the middle of COMPUTE abandons the pair
        send(256'd3, 256'd5, ce);
        while (cyc < ce + 101) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        exp_pass_n = 0;
        exp_fail_n = 0;
        repeat (2) @(negedge clk);
        check_zero_outputs("midrst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (bus.valid_out) seen = 1'b1;
        end
        check("no_output_after_reset", 512'(seen), 512'd0);
        send(256'd1, 256'd1, ce);
        wait_drain("drain_after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/byang_inv_check.md
BYANG_INV_CHECK -- requirements
Module: byang_inv_check

Interface
REQ-001 Parameter PRIME_BITS, default 256, SHALL set the operand and product width; value comes from byang_pkg.vh.
REQ-002 Parameter CTR_WIDTH, default 16, SHALL set the cycle and perf counter width; value comes from byang_pkg.vh.
REQ-003 Constant SECP256K1_P, the secp256k1 prime, SHALL be the modulus p; value comes from byang_pkg.vh.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 valid_in  input  1  operand pair offered.
REQ-008 ready_in  output  1  checker can accept a pair.
REQ-009 a_in  input  PRIME_BITS  original operand a.
REQ-010 r_in  input  PRIME_BITS  claimed inverse r, as produced by the inverter result port.
REQ-011 valid_out  output  1  check result available.
REQ-012 ready_out  input  1  downstream accepts the result.
REQ-013 product  output  PRIME_BITS  (a*r) mod p, fully reduced to [0, p-1].
REQ-014 pass  output  1  1 iff product == 1.
REQ-015 cycle_count  output  CTR_WIDTH  COMPUTE cycles used for this result.
REQ-016 perf_pass_count  output  CTR_WIDTH  running count of results with pass=1; saturates at all-ones.
REQ-017 perf_fail_count  output  CTR_WIDTH  running count of results with pass=0; saturates at all-ones.

Function
REQ-018 Input buffer: ready_in SHALL equal NOT input_valid; a pair is captured when valid_in && ready_in.
REQ-019 The input buffer SHALL clear one cycle after the FSM loads the pair, so one pair can be buffered while another computes.
REQ-020 FSM states SHALL be IDLE, COMPUTE and DONE; any illegal encoding SHALL go to IDLE.
REQ-021 IDLE with a buffered pair SHALL load and go to COMPUTE.
REQ-022 Load action: acc=0; A = a_in reduced (a_in>=p ? a_in-p : a_in); B = r_in reduced likewise; bit index = PRIME_BITS-1; cycle counter = 0.
REQ-023 Each COMPUTE cycle SHALL do one MSB-first interleaved step.
- t = 2*acc; if t >= p then t -= p.
- If B[idx]: t += A; if t >= p then t -= p.
- acc = t.
- Intermediates SHALL be PRIME_BITS+1 bits wide, with no truncation before the compare.
REQ-024 COMPUTE SHALL increment the cycle counter every cycle and take exactly PRIME_BITS cycles; after the step at idx==0 the FSM SHALL go to DONE.
REQ-025 DONE SHALL wait for the output register to be free: NOT valid_out, or valid_out && ready_out in the same cycle.
REQ-026 When the output register is free, DONE SHALL register product=acc, pass=(acc==1) and cycle_count, and set valid_out.
REQ-027 In that same DONE cycle, the perf counter for the matching outcome SHALL increment, saturating at all-ones.
REQ-028 In that same DONE cycle, if a pair is buffered, the FSM SHALL load it and go to COMPUTE directly (back-to-back); otherwise it SHALL go to IDLE.
REQ-029 valid_out SHALL clear on valid_out && ready_out unless it is reloaded in the same cycle.
REQ-030 While valid_out=1 and ready_out=0, product, pass and cycle_count SHALL hold stable.
REQ-031 Latency: from pair capture to valid_out SHALL be PRIME_BITS+3 cycles when the FSM is idle and the output is free.
REQ-032 Zero operand: a≡0 or r≡0 SHALL yield product=0, pass=0, with no special-casing.
REQ-033 Perf counters SHALL never wrap and SHALL be cleared only by reset.

Reset
REQ-034 On rst_n low, asynchronously: state=IDLE, input buffer empty (ready_in=1), valid_out=0, product=0, pass=0, cycle_count=0, both perf counters=0.
REQ-035 Working registers (acc, A, B, idx) need no reset value; they SHALL be written on load before use.
REQ-036 Reset asserted mid-COMPUTE SHALL abandon the computation with no output produced; the first pair after reset SHALL compute correctly.

Verification
REQ-037 a=1, r=1 -> product=1, pass=1, cycle_count=256, perf_pass_count=1.
REQ-038 a=2, r=2^255-2^31-488 (=(p+1)/2) -> product=1, pass=1.
REQ-039 a=p+1 (unreduced), r=5 -> product=5, pass=0, perf_fail_count increments by 1.
REQ-040 a=0, r=7 -> product=0, pass=0.
REQ-041 Three pairs back-to-back with ready_out=0 for 600 cycles:
- First result holds stable.
- Second pair waits in DONE; third pair is buffered with ready_in=0.
- After ready_out=1, results arrive in order with no loss.
REQ-042 rst_n pulsed low at COMPUTE cycle 100 -> valid_out stays 0, all outputs and counters are 0; the next pair a=1, r=1 -> pass=1.
